// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised fetch program counter with jumps and a hardware return stack
module pc_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int STEP         = 2,
  parameter int STACK_DEPTH  = 4,
  parameter int RESET_VECTOR = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [2:0]                     op,
  input  logic                           zero_flag,
  input  logic [ADDR_W-1:0]              target,
  output logic [ADDR_W-1:0]              current_address,
  output logic [$clog2(STACK_DEPTH):0]   stack_depth,
  output logic                           stack_overflow,
  output logic                           stack_underflow
);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam int DW = IW + 1;
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RST_A  = ADDR_W'(RESET_VECTOR);
  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JUMP = 3'd1,
    OP_JZ   = 3'd2,
    OP_JNZ  = 3'd3,
    OP_JREL = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] seq;
  logic [IW-1:0]     top_idx;
  logic              full;
  logic              empty;
  op_e               op_t;
  assign op_t    = op_e'(op);
  assign seq     = pc_q + STEP_A;
  assign full    = depth_q == DW'(STACK_DEPTH);
  assign empty   = depth_q == '0;
  // Low index bits wrap so a full stack (index bits all zero) still points at its top entry.
  assign top_idx = depth_q[IW-1:0] - IW'(1);
  // Next-state decode; JREL adds the offset at full width, which is exactly sign-extended two's-complement addition.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (enable) begin
      unique case (op_t)
        OP_JUMP: pc_d = target;
        OP_JZ:   pc_d = zero_flag ? target : seq;
        OP_JNZ:  pc_d = zero_flag ? seq : target;
        OP_JREL: pc_d = pc_q + target;
        OP_CALL: begin
          push    = !full;
          pc_d    = full ? seq : target;
          depth_d = full ? depth_q : depth_q + DW'(1);
          ovf_d   = ovf_q | full;
        end
        OP_RET: begin
          pc_d    = empty ? seq : stack_q[top_idx];
          depth_d = empty ? depth_q : depth_q - DW'(1);
          unf_d   = unf_q | empty;
        end
        default: pc_d = seq;
      endcase
    end
  end
  // Control state with asynchronous reset; stale stack entries become unreachable once depth clears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RST_A;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  // Return-stack storage, deliberately unreset; writes only on a successful CALL.
  always_ff @(posedge clock) begin
    if (push && !reset) stack_q[depth_q[IW-1:0]] <= seq;
  end
  assign current_address = pc_q;
  assign stack_depth     = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test of pc_sequencer against a queue-based reference model
module tb_pc_sequencer;
  localparam int AW = 8;
  localparam int ST = 2;
  localparam int SD = 4;
  localparam int RV = 'h10;
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    op = 3'd0;
  logic          zero_flag = 1'b0;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] current_address;
  logic [2:0]    stack_depth;
  logic          stack_overflow;
  logic          stack_underflow;
  int checks = 0;
  int errors = 0;
  int m_pc = RV;
  int m_ovf = 0;
  int m_unf = 0;
  int m_stk[$];
  pc_sequencer #(.ADDR_W(AW), .STEP(ST), .STACK_DEPTH(SD), .RESET_VECTOR(RV)) dut (
    .clock(clock), .reset(reset), .enable(enable), .op(op), .zero_flag(zero_flag),
    .target(target), .current_address(current_address), .stack_depth(stack_depth),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pc = RV;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask
  task automatic model_step(input int o, input int t, input bit z);
    int seq;
    seq = (m_pc + ST) % 256;
    case (o)
      1: m_pc = t;
      2: m_pc = z ? t : seq;
      3: m_pc = z ? seq : t;
      4: m_pc = (m_pc + (t >= 128 ? t - 256 : t) + 256) % 256;
      5: if (m_stk.size() < SD) begin m_stk.push_back(seq); m_pc = t; end
         else begin m_pc = seq; m_ovf = 1; end
      6: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else begin m_pc = seq; m_unf = 1; end
      default: m_pc = seq;
    endcase
  endtask
  task automatic step(input int o, input int t, input bit z = 0, input bit en = 1);
    op = 3'(o);
    target = 8'(t);
    zero_flag = z;
    enable = en;
    @(posedge clock);
    if (en) model_step(o, t, z);
    #1;
  endtask
  task automatic apply_reset();
    @(negedge clock);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_pc", current_address, 32'h10);
    chk("rst_async_depth", stack_depth, 32'd0);
    chk("rst_async_flags", {stack_overflow, stack_underflow}, 32'd0);
    op = 3'd1;
    target = 8'h99;
    enable = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_edge_ignored", current_address, 32'h10);
    @(negedge clock);
    reset = 1'b0;
  endtask
  // Every falling edge: the DUT must agree with the model in full.
  always @(negedge clock) begin
    chk("model_pc", current_address, 32'(m_pc));
    chk("model_depth", stack_depth, 32'(m_stk.size()));
    chk("model_ovf", stack_overflow, 32'(m_ovf));
    chk("model_unf", stack_underflow, 32'(m_unf));
  end
  initial begin
    #1 reset = 1'b1;
    model_reset();
    #16 reset = 1'b0;
    // reset and sequential stepping
    step(0, 0); chk("t1_next1", current_address, 32'h12);
    step(0, 0); chk("t1_next2", current_address, 32'h14);
    step(0, 0); chk("t1_next3", current_address, 32'h16);
    step(1, 'h55, 0, 0);
    step(5, 'h55, 0, 0); chk("t1_hold", current_address, 32'h16);
    step(7, 0); chk("t1_reserved", current_address, 32'h18);
    apply_reset();
    // conditional branches
    step(1, 'h20); step(2, 'h80, 1); chk("t2_jz_taken", current_address, 32'h80);
    step(1, 'h20); step(2, 'h80, 0); chk("t2_jz_not", current_address, 32'h22);
    step(1, 'h20); step(3, 'h80, 0); chk("t2_jnz_taken", current_address, 32'h80);
    step(3, 'h30, 1); chk("t2_jnz_not", current_address, 32'h82);
    step(1, 'h40, 1); chk("t2_jump", current_address, 32'h40);
    // relative jumps and wrap
    step(1, 'hFE); step(0, 0); chk("t3_wrap", current_address, 32'h00);
    step(1, 'h10); step(4, 'hF8); chk("t3_jrel_neg", current_address, 32'h08);
    step(1, 'hF0); step(4, 'h20); chk("t3_jrel_wrap", current_address, 32'h10);
    step(4, 'h00); chk("t3_jrel_self", current_address, 32'h10);
    // call / return nesting
    step(1, 'h00);
    step(5, 'h40); chk("t4_call1", {current_address, 5'(stack_depth)}, {8'h40, 5'd1});
    step(5, 'h80); chk("t4_call2", {current_address, 5'(stack_depth)}, {8'h80, 5'd2});
    step(6, 'h99); chk("t4_ret1", {current_address, 5'(stack_depth)}, {8'h42, 5'd1});
    step(6, 'h99); chk("t4_ret2", {current_address, 5'(stack_depth)}, {8'h02, 5'd0});
    chk("t4_flags", {stack_overflow, stack_underflow}, 32'd0);
    // overflow and underflow
    step(1, 'h00);
    for (int i = 0; i < 5; i++) step(5, 'h40);
    chk("t5_ovf_pc", current_address, 32'h42);
    chk("t5_ovf_depth", stack_depth, 32'd4);
    chk("t5_ovf_flag", stack_overflow, 32'd1);
    for (int i = 0; i < 5; i++) step(6, 0);
    chk("t5_unf_pc", current_address, 32'h04);
    chk("t5_unf_depth", stack_depth, 32'd0);
    chk("t5_sticky", {stack_overflow, stack_underflow}, 32'd3);
    step(5, 'h70, 0, 0); chk("t5_en_hold", current_address, 32'h04);
    step(0, 0); chk("t5_still_sticky", {stack_overflow, stack_underflow}, 32'd3);
    // reset mid-stack
    apply_reset();
    step(5, 'h40); step(5, 'h40);
    chk("t6_depth2", stack_depth, 32'd2);
    apply_reset();
    step(6, 0);
    chk("t6_ret_pc", current_address, 32'h12);
    chk("t6_ret_unf", {stack_depth, stack_underflow}, 32'd1);
    // back-to-back call/return
    step(5, 'h60); step(6, 0);
    chk("b2b_ret", {current_address, 5'(stack_depth)}, {8'h14, 5'd0});
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter and sequencer that replaces the fixed 8-bit, step-2 counter in the fetch stage. It supports:

- sequential advance by a configurable step;
- absolute jumps, conditional jumps (on zero and on not-zero) and PC-relative jumps;
- subroutine call/return through an internal hardware return stack, with sticky overflow/underflow fault flags.

It drives the instruction-memory address and is stepped once per instruction by the control unit via `enable`.

## Interface
Parameters:
- `ADDR_W`, default 8: address width in bits.
- `STEP`, default 2: increment applied on sequential advance, in address units; must be less than 2^ADDR_W.
- `STACK_DEPTH`, default 4: number of return-stack entries; must be a power of two and at least 2.
- `RESET_VECTOR`, default 0: value loaded into `current_address` on reset.

Ports:
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `enable`, input, 1: advance strobe; when low, all state holds.
- `op`, input, 3: operation select. 0=NEXT, 1=JUMP, 2=JZ, 3=JNZ, 4=JREL, 5=CALL, 6=RET, 7=reserved (behaves as NEXT).
- `zero_flag`, input, 1: ALU zero flag; sampled only for JZ/JNZ.
- `target`, input, ADDR_W: absolute target for JUMP/JZ/JNZ/CALL; signed two's-complement offset for JREL.
- `current_address`, output, ADDR_W: registered fetch address.
- `stack_depth`, output, $clog2(STACK_DEPTH)+1: number of valid return-stack entries.
- `stack_overflow`, output, 1: sticky; set by a CALL while the stack is full.
- `stack_underflow`, output, 1: sticky; set by a RET while the stack is empty.

## Operation
- Define `seq = current_address + STEP`, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
- All updates happen only on a rising edge with `enable`=1 and `reset`=0.
- NEXT / reserved: `current_address` <= `seq`.
- JUMP: `current_address` <= `target`.
- JZ: `current_address` <= `target` if `zero_flag`=1, else `seq`.
- JNZ: `current_address` <= `target` if `zero_flag`=0, else `seq`.
- JREL: `current_address` <= `current_address` + sign-extended `target`, truncated to ADDR_W.
  - The offset is relative to the current instruction address, not to `seq`.
  - A `target` of 0 therefore holds the PC (self-loop).
- CALL, stack not full:
  - push `seq` at index `stack_depth`;
  - `stack_depth` += 1;
  - `current_address` <= `target`.
- CALL, stack full (`stack_depth`==STACK_DEPTH):
  - no push, no jump;
  - `current_address` <= `seq`;
  - `stack_overflow` <= 1.
- RET, stack not empty:
  - `current_address` <= entry[`stack_depth`-1];
  - `stack_depth` -= 1.
- RET, stack empty:
  - `current_address` <= `seq`;
  - `stack_underflow` <= 1;
  - depth stays 0.
- Sticky flags clear only on reset.
- Return-stack storage is not reset. Only `stack_depth` is reset, so stale entries are never observable.
- `zero_flag` and `target` are ignored by every op that does not use them.

## Timing
- Reset values, applied immediately on `reset` assertion with no clock needed:
  - `current_address`=RESET_VECTOR;
  - `stack_depth`=0;
  - `stack_overflow`=0 and `stack_underflow`=0.
- While `reset` is high, all edges are ignored.
- A reset asserted mid-call-sequence discards every stack content.
- The first update occurs on the first rising edge after `reset` deasserts with `enable`=1.
- Latency is one cycle. `op`, `target` and `zero_flag` sampled at edge N are reflected on `current_address`, `stack_depth` and the flags immediately after edge N.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `enable`=0: every register holds, including the flags, regardless of `op`.
- Back-to-back CALL/RET on consecutive enabled cycles is fully supported. The RET uses the entry pushed on the previous edge (internal state, no bypass needed).
- Wrap-around:
  - `seq` from 2^ADDR_W-STEP wraps to 0;
  - a JREL result wraps modulo 2^ADDR_W;
  - a pushed return address is the wrapped `seq`.

## Test plan
1. **Reset/step.** RESET_VECTOR=0x10, STEP=2. Assert reset mid-cycle, release, then apply 3 enabled NEXTs -> `current_address` is 0x10 immediately on assertion, then 0x12, 0x14, 0x16. With `enable`=0 for 2 cycles, the value holds at 0x16.
2. **Conditional branches.** At PC=0x20, `target`=0x80:
   - JZ with zero=1 -> 0x80;
   - at PC=0x20, JZ with zero=0 -> 0x22;
   - at PC=0x20, JNZ with zero=0 -> 0x80;
   - JUMP 0x40 -> 0x40 regardless of `zero_flag`.
3. **Relative/wrap.** ADDR_W=8:
   - PC=0xFE, NEXT -> 0x00;
   - PC=0x10, JREL `target`=0xF8 (-8) -> 0x08;
   - PC=0xF0, JREL +0x20 -> 0x10.
4. **Call/return nesting.** From PC=0x00:
   - CALL 0x40 -> PC=0x40, depth=1;
   - CALL 0x80 -> PC=0x80, depth=2;
   - RET -> 0x42, depth=1;
   - RET -> 0x02, depth=0;
   - no flags set.
5. **Overflow/underflow.** STACK_DEPTH=4:
   - 5 consecutive CALLs to 0x40 starting at PC=0x00 -> the 5th leaves depth=4, PC=0x42, `stack_overflow`=1;
   - then 5 RETs -> the 5th yields `seq` with `stack_underflow`=1 and depth=0;
   - both flags remain set until reset.
6. **Reset mid-stack.** After 2 CALLs, assert reset -> depth=0 and PC=RESET_VECTOR. The following RET sets `stack_underflow` and returns `seq`.
